cache_control: RTL and testbench
================================

# cache_control

Controller FSM that sequences the 2-way set-associative, write-back, write-allocate L1 cache datapath (8 sets, 9-bit tag, 128-bit lines) between the LC-3b CPU port and physical memory. It reads hit/dirty/LRU status from the datapath and drives every array load enable, the datastore input select, the physical-memory address select and the physical-memory handshake. Hits complete in the request cycle. Misses run an optional writeback followed by a line fill, then replay as a hit.

## Interface
- No parameters. Geometry is fixed by `lc3b_types`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`, `mem_write`  in  1 each  CPU request. The request is held stable until `mem_resp`.
- `mem_resp`  out  1  CPU request complete.
- `pmem_read`, `pmem_write`  out  1 each  physical memory request.
- `pmem_resp`  in  1  physical memory complete.
- `ishit_w1`, `ishit_w2`  in  1 each  way valid and tag match.
- `isdirty_w1`, `isdirty_w2`  in  1 each  way valid and dirty at the indexed set, independent of tag.
- `lru_out`  in  1  way to replace: 0 = way 1, 1 = way 2.
- `load_dirty_w1/w2`, `load_valid_w1/w2`, `load_tag_w1/w2`, `load_datastore_w1/w2`  out  1 each  array write enables.
- `dirty_value`  out  1  value written to the dirty array.
- `load_lru`  out  1  LRU write enable. The datapath writes `~lru_out`.
- `datastore_in_mux_sel`  out  1  0 = CPU-merged line, 1 = `pmem_rdata` line.
- `pmem_addr_sel`  out  1  0 = CPU tag/set, 1 = victim tag/set (writeback).
- `hit_count`, `miss_count`  out  16 each  performance counters.

## Operation
- States: `IDLE`, `WRITEBACK`, `ALLOCATE`. Outputs are Mealy and combinational from state and inputs. All outputs are 0 unless listed for a state.
- **IDLE, no request:** all outputs 0.
- **IDLE, hit, way w:**
  - `mem_resp` = 1 in the same cycle.
  - `load_lru` = 1 only if w equals the way named by `lru_out`.
  - On a write, also assert `load_datastore_ww`, `load_dirty_ww` and `dirty_value` = 1, with `datastore_in_mux_sel` = 0.
  - If both ways report a hit (illegal), way 1 wins.
- **IDLE, miss:**
  - The victim way v is `lru_out`, latched into `victim_q`.
  - If v is dirty, go to `WRITEBACK`; otherwise go to `ALLOCATE`.
- **WRITEBACK:**
  - `pmem_write` = 1 and `pmem_addr_sel` = 1, held until `pmem_resp`.
  - On `pmem_resp`, go to `ALLOCATE`.
- **ALLOCATE:**
  - `pmem_read` = 1 and `pmem_addr_sel` = 0, held.
  - On `pmem_resp`:
    - assert `load_datastore_v`, `load_tag_v`, `load_valid_v` and `load_dirty_v` with `dirty_value` = 0, and `datastore_in_mux_sel` = 1;
    - go to `IDLE`.
  - The replayed request then hits.
- `mem_read` and `mem_write` asserted together are treated as a write.
- `pmem_resp` is ignored in `IDLE`.
- The replay flag `replay_q` is set on leaving `IDLE` on a miss and cleared on the next `IDLE` hit.

## Timing
- Hit latency: 0 cycles after the request is visible. `mem_resp` is in the same cycle.
- Clean miss: 1 cycle in `IDLE` + N cycles in `ALLOCATE` + 1 replay cycle, where N is cycles to `pmem_resp`.
- Dirty miss adds the `WRITEBACK` cycles up to `pmem_resp`.
- `pmem_read` and `pmem_write` are never asserted together. Each drops in the cycle after `pmem_resp`.
- Reset:
  - While `rst` is high, all outputs are 0.
  - Next state is `IDLE`; `victim_q` and `replay_q` are 0.
  - Counters clear.
  - Reset mid-`WRITEBACK` or mid-`ALLOCATE` abandons the transfer with no array write.
- At most one array write cycle per request completion, so the LRU is never toggled twice for one access.

## Configuration
- `CACHE_PERF_CNT_EN` defined:
  - `hit_count` increments on an `IDLE` hit with `replay_q` = 0.
  - `miss_count` increments on each `IDLE` miss.
  - Both are 16-bit, saturate at 0xFFFF and clear on `rst`.
- Undefined: both ports are tied to 16'h0000 and no counter flops are built.

## Structure
- `lc3b_types` gains:
  - `cache_ctrl_state_t` (enum: `IDLE`, `WRITEBACK`, `ALLOCATE`);
  - `CACHE_WAYS` = 2.
- One sub-module, `sat_counter16`, a saturating 16-bit counter with `clk`/`rst`/`inc` ports. It is instantiated twice, under `CACHE_PERF_CNT_EN` only.

## Test plan
- **Read hit, way 2, `lru_out` = 1:** `mem_read` with `ishit_w2` = 1 -> `mem_resp` and `load_lru` = 1 in the same cycle; no `pmem_*`.
- **Write hit, way 1, `lru_out` = 1:** -> `load_datastore_w1`, `load_dirty_w1`, `dirty_value` = 1, `mem_resp` = 1; `load_lru` = 0.
- **Clean miss, `lru_out` = 0, `pmem_resp` after 3 cycles:**
  - `pmem_read` high for 3 cycles;
  - fill cycle asserts `load_*_w1` with `datastore_in_mux_sel` = 1;
  - replay hit gives `mem_resp`;
  - `miss_count` = 1, `hit_count` = 0.
- **Dirty miss, `lru_out` = 1, `isdirty_w2` = 1:**
  - `pmem_write` with `pmem_addr_sel` = 1 until `pmem_resp`;
  - then `pmem_read`, then fill of way 2 with `dirty_value` = 0.
- **`rst` in the 2nd `ALLOCATE` cycle:** all outputs 0 in that cycle; next state `IDLE`; no `load_*` asserted; counters 0.
- **70000 back-to-back hits with `CACHE_PERF_CNT_EN`:** `hit_count` saturates at 0xFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: controller state encoding and associativity.
package lc3b_types;

  localparam int CACHE_WAYS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_ctrl_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/cache_control.sv
// L1 cache controller: hit service, dirty-victim writeback and line fill sequencing.
// Performance counters are built only when CACHE_PERF_CNT_EN is defined.
module cache_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp,
  input  logic        ishit_w1,
  input  logic        ishit_w2,
  input  logic        isdirty_w1,
  input  logic        isdirty_w2,
  input  logic        lru_out,
  output logic        load_dirty_w1,
  output logic        load_dirty_w2,
  output logic        load_valid_w1,
  output logic        load_valid_w2,
  output logic        load_tag_w1,
  output logic        load_tag_w2,
  output logic        load_datastore_w1,
  output logic        load_datastore_w2,
  output logic        dirty_value,
  output logic        load_lru,
  output logic        datastore_in_mux_sel,
  output logic        pmem_addr_sel,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int WAY_BITS = $clog2(CACHE_WAYS);

  cache_ctrl_state_t     state, state_next;
  logic [WAY_BITS-1:0]   victim_q, victim_next;
  logic                  replay_q, replay_next;

  logic request, is_write, hit, hit_way;

  assign request  = mem_read | mem_write;
  assign is_write = mem_write;
  assign hit      = ishit_w1 | ishit_w2;
  assign hit_way  = ~ishit_w1;  // way 1 wins if both report a hit

  // NOTE: every combinational output gets a default first so no latches are inferred.
  always_comb begin
    state_next           = state;
    victim_next          = victim_q;
    replay_next          = replay_q;
    mem_resp             = 1'b0;
    pmem_read            = 1'b0;
    pmem_write           = 1'b0;
    load_dirty_w1        = 1'b0;
    load_dirty_w2        = 1'b0;
    load_valid_w1        = 1'b0;
    load_valid_w2        = 1'b0;
    load_tag_w1          = 1'b0;
    load_tag_w2          = 1'b0;
    load_datastore_w1    = 1'b0;
    load_datastore_w2    = 1'b0;
    dirty_value          = 1'b0;
    load_lru             = 1'b0;
    datastore_in_mux_sel = 1'b0;
    pmem_addr_sel        = 1'b0;

    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (request && hit) begin
            mem_resp    = 1'b1;
            load_lru    = (hit_way == lru_out);
            replay_next = 1'b0;
            if (is_write) begin
              load_datastore_w1 = ~hit_way;
              load_datastore_w2 = hit_way;
              load_dirty_w1     = ~hit_way;
              load_dirty_w2     = hit_way;
              dirty_value       = 1'b1;
            end
          end else if (request) begin
            victim_next = lru_out;
            replay_next = 1'b1;
            state_next  = ((lru_out ? isdirty_w2 : isdirty_w1)) ? WRITEBACK : ALLOCATE;
          end
        end

        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) state_next = ALLOCATE;
        end

        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_datastore_w1    = ~victim_q;
            load_datastore_w2    = victim_q;
            load_tag_w1          = ~victim_q;
            load_tag_w2          = victim_q;
            load_valid_w1        = ~victim_q;
            load_valid_w2        = victim_q;
            load_dirty_w1        = ~victim_q;
            load_dirty_w2        = victim_q;
            datastore_in_mux_sel = 1'b1;
            state_next           = IDLE;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
      replay_q <= 1'b0;
    end else begin
      state    <= state_next;
      victim_q <= victim_next;
      replay_q <= replay_next;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic        hit_inc, miss_inc;
  logic [15:0] hit_cnt, miss_cnt;

  // Replayed hits belong to a miss already counted.
  assign hit_inc  = !rst && (state == IDLE) && request && hit && !replay_q;
  assign miss_inc = !rst && (state == IDLE) && request && !hit;

  sat_counter16 u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter16 u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

  assign hit_count  = rst ? 16'h0000 : hit_cnt;
  assign miss_count = rst ? 16'h0000 : miss_cnt;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, clean/dirty misses, reset abort, counter saturation.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_resp;
  logic        pmem_read, pmem_write, pmem_resp;
  logic        ishit_w1, ishit_w2, isdirty_w1, isdirty_w2, lru_out;
  logic        load_dirty_w1, load_dirty_w2, load_valid_w1, load_valid_w2;
  logic        load_tag_w1, load_tag_w2, load_datastore_w1, load_datastore_w2;
  logic        dirty_value, load_lru, datastore_in_mux_sel, pmem_addr_sel;
  logic [15:0] hit_count, miss_count;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector bit positions
  localparam logic [14:0] RESP = 15'h4000, PRD  = 15'h2000, PWR  = 15'h1000,
                          DTY1 = 15'h0800, DTY2 = 15'h0400, VAL1 = 15'h0200,
                          VAL2 = 15'h0100, TAG1 = 15'h0080, TAG2 = 15'h0040,
                          DS1  = 15'h0020, DS2  = 15'h0010, DV   = 15'h0008,
                          LRU  = 15'h0004, MUX  = 15'h0002, ASEL = 15'h0001;
  localparam logic [14:0] FILL1 = DS1 | TAG1 | VAL1 | DTY1 | MUX | PRD;
  localparam logic [14:0] FILL2 = DS2 | TAG2 | VAL2 | DTY2 | MUX | PRD;

  logic [14:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, load_dirty_w1, load_dirty_w2,
                 load_valid_w1, load_valid_w2, load_tag_w1, load_tag_w2,
                 load_datastore_w1, load_datastore_w2, dirty_value, load_lru,
                 datastore_in_mux_sel, pmem_addr_sel};

  cache_control dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_resp             (mem_resp),
    .pmem_read            (pmem_read),
    .pmem_write           (pmem_write),
    .pmem_resp            (pmem_resp),
    .ishit_w1             (ishit_w1),
    .ishit_w2             (ishit_w2),
    .isdirty_w1           (isdirty_w1),
    .isdirty_w2           (isdirty_w2),
    .lru_out              (lru_out),
    .load_dirty_w1        (load_dirty_w1),
    .load_dirty_w2        (load_dirty_w2),
    .load_valid_w1        (load_valid_w1),
    .load_valid_w2        (load_valid_w2),
    .load_tag_w1          (load_tag_w1),
    .load_tag_w2          (load_tag_w2),
    .load_datastore_w1    (load_datastore_w1),
    .load_datastore_w2    (load_datastore_w2),
    .dirty_value          (dirty_value),
    .load_lru             (load_lru),
    .datastore_in_mux_sel (datastore_in_mux_sel),
    .pmem_addr_sel        (pmem_addr_sel),
    .hit_count            (hit_count),
    .miss_count           (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic rd, input logic wr, input logic h1, input logic h2,
                       input logic d1, input logic d2, input logic lru, input logic presp);
    mem_read = rd; mem_write = wr; ishit_w1 = h1; ishit_w2 = h2;
    isdirty_w1 = d1; isdirty_w2 = d2; lru_out = lru; pmem_resp = presp;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int hits, input int misses);
    check({tag, "_hits"},   {16'h0, hit_count},  PERF ? hits   : 0);
    check({tag, "_misses"}, {16'h0, miss_count}, PERF ? misses : 0);
  endtask

  initial begin
    int n_sat;
    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 0, 1, 1);
    check("reset_outputs", outs, 15'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Idle, no request
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_no_req", outs, 15'h0);
    check_counts("after_reset", 0, 0);

    // Read hit way 2, LRU names way 2
    drive(1, 0, 0, 1, 0, 0, 1, 0);
    check("read_hit_w2", outs, RESP | LRU);
    next_cycle();

    // Write hit way 1, LRU names way 2
    drive(0, 1, 1, 0, 0, 0, 1, 0);
    check("write_hit_w1", outs, RESP | DS1 | DTY1 | DV);
    next_cycle();
    check_counts("two_hits", 2, 0);

    // Clean miss, victim way 1; pmem_resp on the third ALLOCATE cycle
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("clean_miss_idle", outs, 15'h0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 0);  // lru_out moves; victim must stay way 1
    check("alloc_c1", outs, PRD);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    check("alloc_c2", outs, PRD);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    check("alloc_fill_w1", outs, FILL1);
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 1, 0);
    check("clean_replay", outs, RESP);
    next_cycle();
    check_counts("clean_miss", 2, 1);

    // pmem_resp in IDLE must not move the FSM
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("idle_pmem_resp", outs, 15'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_stays", outs, 15'h0);

    // Dirty miss, victim way 2, write request
    drive(0, 1, 0, 0, 0, 1, 1, 0);
    check("dirty_miss_idle", outs, 15'h0);
    next_cycle();
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    check("wb_c1", outs, PWR | ASEL);
    next_cycle();
    drive(0, 1, 0, 0, 0, 1, 0, 1);
    check("wb_resp", outs, PWR | ASEL);
    next_cycle();
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    check("dirty_alloc_c1", outs, PRD);
    next_cycle();
    drive(0, 1, 0, 0, 0, 1, 0, 1);
    check("alloc_fill_w2", outs, FILL2);
    next_cycle();
    drive(0, 1, 0, 1, 0, 0, 1, 0);
    check("dirty_replay", outs, RESP | LRU | DS2 | DTY2 | DV);
    next_cycle();
    check_counts("dirty_miss", 2, 2);

    // Read and write together behave as a write; way 1 hit, LRU names way 1
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    check("rw_hit_w1", outs, RESP | LRU | DS1 | DTY1 | DV);
    next_cycle();

    // Both ways hit: way 1 wins, LRU names way 2 so no LRU update
    drive(1, 0, 1, 1, 0, 0, 1, 0);
    check("double_hit", outs, RESP);
    next_cycle();
    check_counts("pre_abort", 4, 2);

    // Reset during the second ALLOCATE cycle abandons the fill
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("abort_alloc_c1", outs, PRD);
    next_cycle();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    check("abort_rst_outs", outs, 15'h0);
    check_counts("abort_rst", 0, 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("abort_idle", outs, 15'h0);
    check_counts("abort_after", 0, 0);
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    check("post_abort_hit", outs, RESP | LRU);
    next_cycle();
    check_counts("post_abort", 1, 0);

    // Back-to-back hits drive the hit counter into saturation
    n_sat = PERF ? 70000 : 20;
    for (int i = 0; i < n_sat; i++) @(posedge clk);
    @(negedge clk);
    check("hit_saturate", {16'h0, hit_count}, PERF ? 32'h0000_FFFF : 32'h0);
    check("miss_after_sat", {16'h0, miss_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
